// File: rtl/buzz_pkg.sv
// Shared encodings and default timing for the buzzer scheduler.
package buzz_pkg;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_KEY  = 2'd1;
  localparam logic [1:0] SRC_DONE = 2'd2;
  localparam logic [1:0] SRC_ALM  = 2'd3;

  typedef enum logic [2:0] {IDLE, KEY, MEL, ALM_ON, ALM_OFF} state_t;

  localparam int DEF_TICK_DIV   = 100000;
  localparam int DEF_KEY_MS     = 50;
  localparam int DEF_MEL_MS     = 6000;
  localparam int DEF_ALM_ON_MS  = 500;
  localparam int DEF_ALM_OFF_MS = 500;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond prescaler plus ms counter; expire pulses on the last clk cycle of len_ms.
module ms_timer #(
  parameter int TICK_DIV = 100000,
  parameter int MSW      = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           restart,
  input  logic [MSW-1:0] len_ms,
  output logic           expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]  pre;
  logic [MSW-1:0] ms;
  logic           tick_last;

  assign tick_last = (pre == PW'(TICK_DIV - 1));
  assign expire    = tick_last && (ms == len_ms - MSW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      ms  <= '0;
    end else if (restart) begin
      pre <= '0;
      ms  <= '0;
    end else if (tick_last) begin
      pre <= '0;
      ms  <= ms + MSW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // A zero-length state would never expire.
  a_len_nonzero: assert property (@(posedge clk) disable iff (!rst) len_ms != '0);

endmodule

// File: rtl/buzz_sched.sv
// Buzzer arbiter: alarm > done > key, each shaped into timed tone/melody windows.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int KEY_MS     = DEF_KEY_MS,
  parameter int MEL_MS     = DEF_MEL_MS,
  parameter int ALM_ON_MS  = DEF_ALM_ON_MS,
  parameter int ALM_OFF_MS = DEF_ALM_OFF_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_req,
  input  logic       done_req,
  input  logic       alm_req,
  input  logic       alm_clr,
  output logic       tone_on,
  output logic       mel_ena,
  output logic       busy,
  output logic [1:0] src
);

  localparam int MS_MAX = max2(max2(KEY_MS, MEL_MS), max2(ALM_ON_MS, ALM_OFF_MS));
  localparam int MSW    = max2(13, $clog2(MS_MAX + 1));

  state_t         state, nxt;
  logic           pend_done, pend_alm;
  logic           pa, pd, in_alm, rs;
  logic           restart, expire;
  logic [MSW-1:0] len_ms;

  assign in_alm = (state == ALM_ON) || (state == ALM_OFF);
  assign pa     = pend_alm | alm_req;
  assign pd     = pend_done | done_req;

  always_comb begin
    len_ms = MSW'(KEY_MS);
    case (state)
      MEL:     len_ms = MSW'(MEL_MS);
      ALM_ON:  len_ms = MSW'(ALM_ON_MS);
      ALM_OFF: len_ms = MSW'(ALM_OFF_MS);
      default: len_ms = MSW'(KEY_MS);
    endcase
  end

  always_comb begin
    nxt = state;
    rs  = 1'b0;
    case (state)
      IDLE: begin
        if (pa)           nxt = ALM_ON;
        else if (pd)      nxt = MEL;
        else if (key_req) nxt = KEY;
      end
      KEY: begin
        if (pa)           nxt = ALM_ON;
        else if (pd)      nxt = MEL;
        else if (key_req) rs  = 1'b1;
        else if (expire)  nxt = IDLE;
      end
      MEL: begin
        if (pa)            nxt = ALM_ON;
        else if (done_req) rs  = 1'b1;
        else if (expire)   nxt = IDLE;
      end
      ALM_ON, ALM_OFF: begin
        if (alm_clr && alm_req) begin
          nxt = ALM_ON;
          rs  = 1'b1;
        end else if (alm_clr) begin
          nxt = pd ? MEL : IDLE;
        end else if (expire) begin
          nxt = (state == ALM_ON) ? ALM_OFF : ALM_ON;
        end
      end
      default: nxt = IDLE;
    endcase
    // Holding the timer cleared in IDLE keeps the ms counter from ever wrapping.
    restart = rs || (nxt != state) || (state == IDLE);
  end

  ms_timer #(.TICK_DIV(TICK_DIV), .MSW(MSW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .len_ms  (len_ms),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend_done <= 1'b0;
      pend_alm  <= 1'b0;
      tone_on   <= 1'b0;
      mel_ena   <= 1'b0;
      busy      <= 1'b0;
      src       <= SRC_NONE;
    end else begin
      state     <= nxt;
      pend_done <= pd && (nxt != MEL);
      pend_alm  <= pa && !in_alm && (nxt != ALM_ON) && !(alm_clr && !alm_req);
      tone_on   <= (nxt == KEY) || (nxt == ALM_ON);
      mel_ena   <= (nxt == MEL);
      busy      <= (nxt != IDLE);
      case (nxt)
        KEY:             src <= SRC_KEY;
        MEL:             src <= SRC_DONE;
        ALM_ON, ALM_OFF: src <= SRC_ALM;
        default:         src <= SRC_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_buzz_sched.sv
// Scoreboard bench: stimulus queues expected output changes with cycle stamps; monitor checks each change.
module tb_buzz_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_req = 1'b0, done_req = 1'b0, alm_req = 1'b0, alm_clr = 1'b0;
  logic       tone_on, mel_ena, busy;
  logic [1:0] src;
  logic [4:0] ov;

  typedef struct {
    int         stamp;
    logic [4:0] v;
  } exp_t;

  localparam logic [4:0] V_IDL  = 5'b00000;
  localparam logic [4:0] V_KEY  = 5'b10101;
  localparam logic [4:0] V_MEL  = 5'b01110;
  localparam logic [4:0] V_AON  = 5'b10111;
  localparam logic [4:0] V_AOFF = 5'b00111;

  exp_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [4:0] prev = 5'b00000;
  int         a;

  buzz_sched #(
    .TICK_DIV(4), .KEY_MS(2), .MEL_MS(5), .ALM_ON_MS(3), .ALM_OFF_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .key_req(key_req), .done_req(done_req),
    .alm_req(alm_req), .alm_clr(alm_clr), .tone_on(tone_on),
    .mel_ena(mel_ena), .busy(busy), .src(src)
  );

  assign ov = {tone_on, mel_ena, busy, src};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && ov !== prev) begin
      exp_t e;
      prev = ov;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: got %b at cycle %0d, want no change", ov, cyc);
      end else begin
        e = q.pop_front();
        if (ov !== e.v || cyc != e.stamp) begin
          n_bad++;
          $display("FAIL out_change: got %b at cycle %0d, want %b at cycle %0d", ov, cyc, e.v, e.stamp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic k, input logic d, input logic al, input logic c);
    key_req = k; done_req = d; alm_req = al; alm_clr = c;
    tick(1);
    key_req = 1'b0; done_req = 1'b0; alm_req = 1'b0; alm_clr = 1'b0;
  endtask

  task automatic expect_at(input int st, input logic [4:0] v);
    q.push_back('{st, v});
  endtask

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk("reset_hold", ov, V_IDL);
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("after_reset", ov, V_IDL);
    mon_en = 1'b1;

    // 1: async reset during ALM_ON, then a lone alm_clr does nothing
    pulse(0, 0, 1, 0); a = cyc;
    expect_at(a, V_AON);
    tick(5);
    expect_at(cyc, V_IDL);
    rst = 1'b0;
    #1 chk("async_reset", ov, V_IDL);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("idle_after_release", ov, V_IDL);
    pulse(0, 0, 0, 1);
    tick(10);
    chk("lone_clr_idle", ov, V_IDL);

    // 2: key beep 8 cycles; re-press restarts to 13 cycles total
    pulse(1, 0, 0, 0); a = cyc;
    expect_at(a, V_KEY); expect_at(a + 8, V_IDL);
    tick(12);
    pulse(1, 0, 0, 0); a = cyc;
    expect_at(a, V_KEY); expect_at(a + 13, V_IDL);
    tick(4);
    pulse(1, 0, 0, 0);
    tick(16);

    // 3: melody 20 cycles, key during MEL is dropped
    pulse(0, 1, 0, 0); a = cyc;
    expect_at(a, V_MEL); expect_at(a + 20, V_IDL);
    tick(3);
    pulse(1, 0, 0, 0);
    tick(20);
    chk("mel_end_idle", ov, V_IDL);

    // 4: alarm preempts MEL at cycle 6, 12 on / 8 off, clr -> IDLE, no MEL resume
    pulse(0, 1, 0, 0); a = cyc;
    expect_at(a, V_MEL);
    tick(5);
    pulse(0, 0, 1, 0);
    if (cyc != a + 6) begin
      n_cmp++; n_bad++;
      $display("FAIL alm_preempt_edge: got %0d want %0d", cyc, a + 6);
    end
    a = cyc;
    expect_at(a, V_AON);      expect_at(a + 12, V_AOFF);
    expect_at(a + 20, V_AON); expect_at(a + 32, V_AOFF);
    expect_at(a + 34, V_IDL);
    tick(33);
    pulse(0, 0, 0, 1);
    tick(25);

    // 5: alarm and done together -> alarm first, then MEL after clr
    pulse(0, 1, 1, 0); a = cyc;
    expect_at(a, V_AON); expect_at(a + 12, V_AOFF);
    expect_at(a + 14, V_MEL); expect_at(a + 34, V_IDL);
    tick(13);
    pulse(0, 0, 0, 1);
    tick(25);

    // 6: clr and req together in ALM_OFF restarts a full ALM_ON
    pulse(0, 0, 1, 0); a = cyc;
    expect_at(a, V_AON); expect_at(a + 12, V_AOFF);
    expect_at(a + 14, V_AON); expect_at(a + 26, V_AOFF);
    expect_at(a + 28, V_IDL);
    tick(13);
    pulse(0, 0, 1, 1);
    tick(13);
    pulse(0, 0, 0, 1);
    tick(5);
    chk("final_idle", ov, V_IDL);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expects: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buzz_sched.md
Name: buzz_sched

Overview:
- Arbitrates and sequences use of the washing-machine buzzer between three requesters: key click, cycle-done melody and fault alarm.
- Drives the enable of the melody player and a plain tone enable for beeps.
- Shapes each request into a timed on/off pattern using a millisecond tick prescaler.
- Sits between the control FSM / key scanner and the buzzer tone and melody generators.

Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz clock).
- KEY_MS, 50: key-click beep length, in ms.
- MEL_MS, 6000: melody play window after cycle done, in ms.
- ALM_ON_MS, 500: alarm beep on-time, in ms.
- ALM_OFF_MS, 500: alarm beep off-time, in ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- key_req  in  1  one-cycle pulse: key pressed.
- done_req  in  1  one-cycle pulse: wash cycle finished.
- alm_req  in  1  one-cycle pulse: fault raised.
- alm_clr  in  1  one-cycle pulse: fault acknowledged.
- tone_on  out  1  enable for the fixed-tone beeper.
- mel_ena  out  1  enable for the melody generator.
- busy  out  1  scheduler not IDLE.
- src  out  2  active source: 0 none, 1 key, 2 done, 3 alarm.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst). While rst=0 and on release, all outputs are 0, state is IDLE, pending bits are cleared, and the prescaler and ms counter are 0.
- Pending latches:
  - done_req sets pend_done.
  - alm_req sets pend_alm.
  - A pending bit clears in the cycle its source is granted.
  - key_req is never latched. It is accepted only when the state is IDLE or KEY; otherwise it is dropped.
- Priority: alarm > done > key. Preemption is evaluated every cycle and takes effect on the next clock edge.
- States and outputs (all outputs registered; they reflect the state held after the edge):
  - IDLE: tone_on=0, mel_ena=0, src=0.
  - KEY: tone_on=1, src=1, lasts KEY_MS ticks.
  - MEL: mel_ena=1, src=2, lasts MEL_MS ticks.
  - ALM_ON: tone_on=1, src=3, lasts ALM_ON_MS ticks.
  - ALM_OFF: tone_on=0, src=3, lasts ALM_OFF_MS ticks.
- Transitions:
  - IDLE: pend_alm or alm_req → ALM_ON. Else pend_done or done_req → MEL. Else key_req → KEY.
  - KEY expiry → IDLE, or the higher-priority pending state.
  - key_req while in KEY restarts the KEY timer.
  - KEY is preempted immediately by alarm or done.
  - MEL is preempted by alarm. A done_req during MEL restarts MEL.
  - MEL expiry → IDLE, or ALM_ON if alarm is pending.
  - ALM_ON ↔ ALM_OFF alternate indefinitely until alm_clr.
  - alm_clr in ALM_ON or ALM_OFF → IDLE next cycle, or MEL if pend_done.
  - alm_clr and alm_req in the same cycle: alm_req wins; restart in ALM_ON.
  - alm_clr when not in an alarm state: also clears pend_alm.
- Timing:
  - The prescaler and ms counter reset on every state entry, including restarts.
  - A state of N ms therefore lasts exactly N*TICK_DIV clk cycles.
  - Latency from a request pulse in IDLE to the output asserting is 1 cycle.
- Widths: prescaler is clog2(TICK_DIV) bits; ms counter is 13 bits minimum, sized to the largest ms parameter. No wrap is possible within a state. A duration parameter of 0 is illegal; check it with an assertion.
- Preempted sources are not resumed. A preempted MEL (pend_done already cleared) is lost. A preempted KEY is lost.

Decomposition:
- Package buzz_pkg holds:
  - src encoding constants (SRC_NONE/KEY/DONE/ALM);
  - the state enum (IDLE, KEY, MEL, ALM_ON, ALM_OFF);
  - default timing constants.
- One natural sub-module, ms_timer: prescaler plus ms counter, with inputs restart and len_ms and output expire (a one-cycle pulse on the last cycle). The FSM and pending logic stay in buzz_sched.

Test Plan:
All scenarios use TICK_DIV=4, KEY_MS=2, MEL_MS=5, ALM_ON_MS=3, ALM_OFF_MS=2.
1. Reset mid-operation: assert rst=0 during ALM_ON → all outputs 0 immediately (async). After release, IDLE with busy=0; a lone alm_clr has no effect.
2. key_req in IDLE → tone_on=1, src=1 for exactly 8 cycles, then IDLE. A second key_req at cycle 5 extends tone_on to 13 cycles total.
3. done_req in IDLE → mel_ena=1 for 20 cycles. key_req during MEL is dropped: src stays 2 and no beep follows.
4. MEL active, alm_req at cycle 6 → next cycle src=3, tone_on=1, mel_ena=0. Pattern is 12 cycles on / 8 off, repeating. alm_clr at any point → IDLE next cycle, and MEL does not resume.
5. alm_req and done_req in the same cycle from IDLE → ALM_ON. Then alm_clr → MEL for 20 cycles → IDLE.
6. alm_clr and alm_req in the same cycle during ALM_OFF → ALM_ON restarts with tone_on=1 for a full 12 cycles.
